pe_shift_sum: RTL and testbench
===============================

# pe_shift_sum

Shift-accumulate stage that sits directly downstream of the PE arithmetic unit (Aunit). It consumes signed partial products together with their shift-sum control word. It folds them bit-serially (MSB-first) into psum entries held in a local psum pad. On the last pixel it emits the finished psum on a ready/valid output stream toward the PE psum output path.

## Interface
Parameters:
- AuODWd, 11, width of the signed Aunit partial product
- PsumDWd, 16, psum width
- PPadSize, 64, psum pad entries
- PPadAddrWd, $clog2(PPadSize), psum pad index width

Ports:
- clk  in  1  clock; single clock domain
- rst_n  in  1  asynchronous, active-low reset
- au_valid  in  1  partial-product beat valid
- au_ready  out  1  stage can accept a beat
- au_data  in  AuODWd  signed partial product
- au_ctl  in  SSctl  shift-sum control: valid, init, fstpix, lstpix, sht, sht_num
- au_paddr  in  PPadAddrWd  psum pad entry addressed by this beat
- ps_valid  out  1  finished psum valid
- ps_ready  in  1  downstream accepts psum
- ps_data  out  PsumDWd  finished psum
- ps_paddr  out  PPadAddrWd  entry index of the finished psum

## Operation
- A beat transfers on au_valid && au_ready and is registered into S1 (s1_valid, data, ctl, addr).
- A beat with au_ctl.valid=0 is accepted and discarded; it causes no pad or output activity.
- FSM states:
  - RUN: normal accumulation.
  - CLEAR: pad zeroing.
- RUN → CLEAR when S1 holds a beat with init=1. Init beats are command-only, so their au_data is ignored.
  - CLEAR runs a counter 0..PPadSize-1 and writes zero to one pad entry per cycle.
  - CLEAR → RUN after entry PPadSize-1 is written.
- For a data beat, S1 reads pad[addr] combinationally as old (0 when fstpix=1) and then computes:
  - base = sht ? old << n : old, where n ∈ {1,2,4,8} for SHT1/SHT2/SHT4/SHT8.
  - acc = base + sign-extended au_data.
  - Intermediate width is PsumDWd+9 bits, signed two's complement.
  - Result res = acc reduced to PsumDWd (see Configuration).
- If lstpix=0, S1 writes res to pad[addr] when it advances.
- If lstpix=1, S1 loads res and addr into the output register and sets ps_valid; it does not write the pad.
- S1 advances unless it holds an lstpix beat while ps_valid && !ps_ready.
- au_ready = (state==RUN) && (!s1_valid || S1 advances) && !(s1 holds init).
- Same-address beats may arrive back-to-back. The write completes at the clock edge ending the S1 cycle, so the next beat reads the updated entry. No forwarding is required.

## Timing
- Reset values:
  - au_ready=0 during reset and 1 in the first cycle after reset.
  - ps_valid=0, ps_data=0, ps_paddr=0.
  - state=RUN, s1_valid=0, all pad entries 0.
- Latency: a beat accepted at edge T is in S1 during cycle T+1. The pad write lands at edge T+2, and ps_valid rises after edge T+2.
- Throughput: 1 beat/cycle in RUN with ps_ready=1.
- Output handshake: ps_data and ps_paddr are held stable while ps_valid && !ps_ready. ps_valid drops the cycle after transfer unless a new lstpix result loads in the same edge, which supports back-to-back transfers.
- Init: from the acceptance edge of the init beat, au_ready is 0 for PPadSize+1 cycles. Beat acceptance resumes in the cycle after the final clear write.
- An output held during CLEAR stays valid and can transfer during CLEAR.
- Reset mid-CLEAR or mid-stall: all state returns to reset values immediately, the pad reads zero, and pending beats are lost.
- Pad address wrap is not applicable, because addresses are direct.

## Configuration
- PE_PSUM_SAT_EN defined: res saturates to [-2^(PsumDWd-1), 2^(PsumDWd-1)-1].
- PE_PSUM_SAT_EN undefined: res is the low PsumDWd bits of acc (wrap-around).

## Structure
- SSctl, ShtNum, PsumDWd, PPadSize and PPadAddrWd live in the shared PE control package.
- Add a new enum SsState {RUN, CLEAR} to the same package.
- One sub-module, pe_ppad: PPadSize×PsumDWd register file with asynchronous zero reset, combinational read and one synchronous write port.

## Test plan
- fstpix beat data=5 addr=3, then lstpix beat data=3 sht=1 SHT1 addr=3 → ps_data=13, ps_paddr=3, ps_valid two edges after the second acceptance.
- Three back-to-back addr=7 beats: data 1 (fstpix), 0 (sht SHT1), 1 (sht SHT1, lstpix) → ps_data=5; no bubble on au_ready.
- ps_ready=0 with two consecutive lstpix beats → first result held stable, au_ready=0 while S1 holds the second beat; after ps_ready=1, 13 then the second value are delivered in order.
- Init beat after writing pad[10]=9 → au_ready low PPadSize+1 cycles; then a non-fstpix lstpix beat data=2 addr=10 returns ps_data=2.
- old=0x4000, sht SHT2, data=0, lstpix → 0x7FFF with PE_PSUM_SAT_EN, 0x0000 without; data=-1 fstpix → 0xFFFF in both.
- rst_n asserted at clear count 20 → all outputs reset asynchronously; after release au_ready=1 and a non-fstpix read of any entry returns 0 + data.

Source files
------------

// File: rtl/pe_shift_sum_pkg.sv
// Shared PE control package: psum geometry, shift-sum control word and
// shift-sum stage state encoding.
package pe_shift_sum_pkg;

  localparam int unsigned AuODWd     = 11;
  localparam int unsigned PsumDWd    = 16;
  localparam int unsigned PPadSize   = 64;
  localparam int unsigned PPadAddrWd = $clog2(PPadSize);

  typedef enum logic [1:0] {
    SHT1 = 2'd0,
    SHT2 = 2'd1,
    SHT4 = 2'd2,
    SHT8 = 2'd3
  } ShtNum;

  typedef struct packed {
    logic  valid;
    logic  init;
    logic  fstpix;
    logic  lstpix;
    logic  sht;
    ShtNum sht_num;
  } SSctl;

  typedef enum logic {
    RUN   = 1'b0,
    CLEAR = 1'b1
  } SsState;

  function automatic int unsigned sht_amt(input ShtNum n);
    case (n)
      SHT1:    return 1;
      SHT2:    return 2;
      SHT4:    return 4;
      default: return 8;
    endcase
  endfunction

endpackage

// File: rtl/pe_shift_sum_ppad.sv
// Psum pad: register file with asynchronous zero reset, combinational read
// and a single synchronous write port.
module pe_ppad #(
  parameter int unsigned DWd    = 16,
  parameter int unsigned Size   = 64,
  parameter int unsigned AddrWd = $clog2(Size)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [AddrWd-1:0] waddr_i,
  input  logic [DWd-1:0]    wdata_i,
  input  logic [AddrWd-1:0] raddr_i,
  output logic [DWd-1:0]    rdata_o
);

  logic [DWd-1:0] mem_q [Size];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < Size; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/pe_shift_sum.sv
// Bit-serial shift-accumulate stage folding Aunit partial products into a psum
// pad. Build option PE_PSUM_SAT_EN selects saturating instead of wrapping psums.
module pe_shift_sum #(
  parameter int unsigned AuODWd     = pe_shift_sum_pkg::AuODWd,
  parameter int unsigned PsumDWd    = pe_shift_sum_pkg::PsumDWd,
  parameter int unsigned PPadSize   = pe_shift_sum_pkg::PPadSize,
  parameter int unsigned PPadAddrWd = $clog2(PPadSize)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    au_valid,
  output logic                    au_ready,
  input  logic [AuODWd-1:0]       au_data,
  input  pe_shift_sum_pkg::SSctl  au_ctl,
  input  logic [PPadAddrWd-1:0]   au_paddr,
  output logic                    ps_valid,
  input  logic                    ps_ready,
  output logic [PsumDWd-1:0]      ps_data,
  output logic [PPadAddrWd-1:0]   ps_paddr
);

  import pe_shift_sum_pkg::*;

  SsState                  state_q, state_d;
  logic [PPadAddrWd-1:0]   clr_cnt_q, clr_cnt_d;
  logic                    rdy_en_q;

  logic                    s1_valid_q;
  logic [AuODWd-1:0]       s1_data_q;
  SSctl                    s1_ctl_q;
  logic [PPadAddrWd-1:0]   s1_addr_q;

  logic                    ps_valid_q, ps_valid_d;
  logic [PsumDWd-1:0]      ps_data_q;
  logic [PPadAddrWd-1:0]   ps_paddr_q;

  logic                    s1_init, s1_beat, s1_stall, accept, ps_load;
  logic                    pad_we;
  logic [PPadAddrWd-1:0]   pad_waddr;
  logic [PsumDWd-1:0]      pad_wdata, pad_rdata, old, res;

  // Beats whose control word is not valid occupy S1 but are otherwise inert.
  assign s1_init  = s1_valid_q && s1_ctl_q.valid && s1_ctl_q.init;
  assign s1_beat  = s1_valid_q && s1_ctl_q.valid && !s1_ctl_q.init;
  assign s1_stall = s1_beat && s1_ctl_q.lstpix && ps_valid_q && !ps_ready;
  assign ps_load  = s1_beat && s1_ctl_q.lstpix && !s1_stall;

  assign au_ready = rdy_en_q && (state_q == RUN) && !s1_stall && !s1_init;
  assign accept   = au_valid && au_ready;

  assign old = s1_ctl_q.fstpix ? '0 : pad_rdata;

`ifdef PE_PSUM_SAT_EN
  localparam int unsigned AccWd = PsumDWd + 9;
  logic signed [AccWd-1:0] old_w, base_w, acc_w;
  logic                    in_range;

  always_comb begin
    old_w    = {{(AccWd-PsumDWd){old[PsumDWd-1]}}, old};
    base_w   = s1_ctl_q.sht ? (old_w <<< sht_amt(s1_ctl_q.sht_num)) : old_w;
    acc_w    = base_w + {{(AccWd-AuODWd){s1_data_q[AuODWd-1]}}, s1_data_q};
    // Representable iff every bit above the psum sign bit copies it.
    in_range = (&acc_w[AccWd-1:PsumDWd-1]) || (~|acc_w[AccWd-1:PsumDWd-1]);
    res      = in_range ? acc_w[PsumDWd-1:0]
                        : {acc_w[AccWd-1], {(PsumDWd-1){~acc_w[AccWd-1]}}};
  end
`else
  logic [PsumDWd-1:0] base_n;

  // Wrapped result only needs the low PsumDWd bits, which are identical to
  // those of the wide accumulation.
  always_comb begin
    base_n = s1_ctl_q.sht ? (old << sht_amt(s1_ctl_q.sht_num)) : old;
    res    = base_n + {{(PsumDWd-AuODWd){s1_data_q[AuODWd-1]}}, s1_data_q};
  end
`endif

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      RUN: begin
        if (s1_init) begin
          state_d   = CLEAR;
          clr_cnt_d = '0;
        end
      end
      default: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == PPadAddrWd'(PPadSize - 1)) begin
          state_d = RUN;
        end
      end
    endcase
  end

  always_comb begin
    pad_we    = 1'b0;
    pad_waddr = s1_addr_q;
    pad_wdata = res;
    if (state_q == CLEAR) begin
      pad_we    = 1'b1;
      pad_waddr = clr_cnt_q;
      pad_wdata = '0;
    end else if (s1_beat && !s1_ctl_q.lstpix) begin
      pad_we = 1'b1;
    end
  end

  always_comb begin
    ps_valid_d = ps_valid_q;
    if (ps_load) begin
      ps_valid_d = 1'b1;
    end else if (ps_ready) begin
      ps_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      clr_cnt_q  <= '0;
      rdy_en_q   <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_ctl_q   <= '0;
      s1_addr_q  <= '0;
      ps_valid_q <= 1'b0;
      ps_data_q  <= '0;
      ps_paddr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      rdy_en_q   <= 1'b1;
      ps_valid_q <= ps_valid_d;
      if (accept) begin
        s1_valid_q <= 1'b1;
        s1_data_q  <= au_data;
        s1_ctl_q   <= au_ctl;
        s1_addr_q  <= au_paddr;
      end else if (!s1_stall) begin
        s1_valid_q <= 1'b0;
      end
      if (ps_load) begin
        ps_data_q  <= res;
        ps_paddr_q <= s1_addr_q;
      end
    end
  end

  pe_ppad #(
    .DWd    (PsumDWd),
    .Size   (PPadSize),
    .AddrWd (PPadAddrWd)
  ) u_ppad (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (pad_we),
    .waddr_i (pad_waddr),
    .wdata_i (pad_wdata),
    .raddr_i (s1_addr_q),
    .rdata_o (pad_rdata)
  );

  assign ps_valid = ps_valid_q;
  assign ps_data  = ps_data_q;
  assign ps_paddr = ps_paddr_q;

endmodule

// File: tb/tb_pe_shift_sum.sv
// Scoreboard bench for pe_shift_sum: a reference pad model predicts every
// finished psum; outputs are popped and compared as they transfer.
module tb_pe_shift_sum;
  import pe_shift_sum_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        au_valid = 1'b0;
  logic        au_ready;
  logic [10:0] au_data = '0;
  SSctl        au_ctl = '0;
  logic [5:0]  au_paddr = '0;
  logic        ps_valid;
  logic        ps_ready = 1'b1;
  logic [15:0] ps_data;
  logic [5:0]  ps_paddr;

  typedef struct packed {
    logic [15:0] d;
    logic [5:0]  a;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] exp_pad [64];
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  pe_shift_sum #(
    .AuODWd     (11),
    .PsumDWd    (16),
    .PPadSize   (64),
    .PPadAddrWd (6)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .au_valid (au_valid),
    .au_ready (au_ready),
    .au_data  (au_data),
    .au_ctl   (au_ctl),
    .au_paddr (au_paddr),
    .ps_valid (ps_valid),
    .ps_ready (ps_ready),
    .ps_data  (ps_data),
    .ps_paddr (ps_paddr)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] model(input logic [15:0] old, input bit fst, input bit sht,
                                        input ShtNum num, input int data);
    longint acc;
    acc = fst ? 64'sd0 : longint'($signed(old));
    if (sht) acc = acc * (longint'(1) << (2 ** int'(num)));
    acc = acc + longint'(data);
`ifdef PE_PSUM_SAT_EN
    if (acc > 32767) acc = 32767;
    else if (acc < -32768) acc = -32768;
`endif
    return acc[15:0];
  endfunction

  task automatic pad_clear();
    for (int i = 0; i < 64; i++) exp_pad[i] = '0;
  endtask

  // Drives one beat, waits for acceptance, then updates the reference model.
  task automatic send(input int data, input bit fst, input bit lst, input bit sht,
                      input ShtNum num, input int addr, input bit init, input bit vld,
                      output int waits);
    SSctl        c;
    logic [15:0] r;
    c.valid = vld; c.init = init; c.fstpix = fst; c.lstpix = lst; c.sht = sht; c.sht_num = num;
    au_data = 11'(data); au_ctl = c; au_paddr = 6'(addr); au_valid = 1'b1;
    waits = 0;
    while (1) begin
      @(negedge clk);
      if (au_ready) break;
      waits++;
      if (waits > 200) begin
        chk("send_timeout", 32'(waits), 32'd0);
        au_valid = 1'b0;
        return;
      end
    end
    @(posedge clk); #1;
    if (vld) begin
      if (init) pad_clear();
      else begin
        r = model(exp_pad[addr], fst, sht, num, data);
        if (lst) sb.push_back('{d: r, a: 6'(addr)});
        else exp_pad[addr] = r;
      end
    end
  endtask

  task automatic idle(input int n);
    au_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && ps_valid && ps_ready) begin
      if (sb.size() == 0) chk("ps_unexpected", 32'd1, 32'd0);
      else begin
        e = sb.pop_front();
        chk("ps_data", 32'(ps_data), 32'(e.d));
        chk("ps_paddr", 32'(ps_paddr), 32'(e.a));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1);
  end

  initial begin
    int w, n;
    pad_clear();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_au_ready", 32'(au_ready), 32'd0);
    chk("rst_ps_valid", 32'(ps_valid), 32'd0);
    chk("rst_ps_data", 32'(ps_data), 32'd0);
    chk("rst_ps_paddr", 32'(ps_paddr), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_ready", 32'(au_ready), 32'd1);

    // 5 then (5<<1)+3 = 13 at entry 3, with two-edge latency.
    send(5, 1, 0, 0, SHT1, 3, 0, 1, w);
    send(3, 0, 1, 1, SHT1, 3, 0, 1, w);
    idle(0);
    chk("lat_s1", 32'(ps_valid), 32'd0);
    @(posedge clk); #1;
    chk("lat_out", 32'(ps_valid), 32'd1);
    idle(3);

    // Back-to-back same-address beats with no bubble: 1, 2, 5.
    send(1, 1, 0, 0, SHT1, 7, 0, 1, w);
    send(0, 0, 0, 1, SHT1, 7, 0, 1, w);
    chk("b2b_wait2", 32'(w), 32'd0);
    send(1, 0, 1, 1, SHT1, 7, 0, 1, w);
    chk("b2b_wait3", 32'(w), 32'd0);
    idle(4);

    // Output backpressure with two consecutive lstpix beats: 13 then 4.
    ps_ready = 1'b0;
    send(3, 0, 1, 1, SHT1, 3, 0, 1, w);
    send(2, 0, 1, 0, SHT1, 7, 0, 1, w);
    idle(0);
    for (int i = 0; i < 3; i++) begin
      chk("stall_ready", 32'(au_ready), 32'd0);
      chk("stall_valid", 32'(ps_valid), 32'd1);
      chk("stall_data", 32'(ps_data), 32'h000d);
      @(posedge clk); #1;
    end
    ps_ready = 1'b1;
    idle(4);

    // Beat with control valid low: no output, no clear.
    send(100, 1, 1, 0, SHT1, 5, 0, 0, w);
    idle(3);
    chk("novld_ps_valid", 32'(ps_valid), 32'd0);
    chk("novld_ready", 32'(au_ready), 32'd1);

    // Init clears the pad; busy for PPadSize+1 cycles.
    send(9, 1, 0, 0, SHT1, 10, 0, 1, w);
    send(77, 0, 0, 0, SHT1, 0, 1, 1, w);
    idle(0);
    n = 0;
    while (n <= 200) begin
      @(negedge clk);
      if (au_ready) break;
      n++;
    end
    chk("init_busy", 32'(n), 32'd65);
    @(posedge clk); #1;
    send(2, 0, 1, 0, SHT1, 10, 0, 1, w);
    idle(4);

    // Saturation / wrap: 0x4000 << 2, then -1, then large negative.
    send(1, 1, 0, 0, SHT1, 20, 0, 1, w);
    send(0, 0, 0, 1, SHT8, 20, 0, 1, w);
    send(0, 0, 0, 1, SHT4, 20, 0, 1, w);
    send(0, 0, 0, 1, SHT2, 20, 0, 1, w);
    send(0, 0, 1, 1, SHT2, 20, 0, 1, w);
    send(-1, 1, 1, 0, SHT1, 21, 0, 1, w);
    send(-512, 1, 0, 0, SHT1, 23, 0, 1, w);
    send(-1, 0, 1, 1, SHT8, 23, 0, 1, w);
    idle(4);

    // Reset at clear count 20.
    send(7, 1, 0, 0, SHT1, 30, 0, 1, w);
    send(0, 0, 0, 0, SHT1, 0, 1, 1, w);
    idle(21);
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", 32'(au_ready), 32'd0);
    chk("midrst_valid", 32'(ps_valid), 32'd0);
    chk("midrst_data", 32'(ps_data), 32'd0);
    chk("midrst_paddr", 32'(ps_paddr), 32'd0);
    pad_clear();
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rerst_ready", 32'(au_ready), 32'd1);
    send(3, 0, 1, 0, SHT1, 30, 0, 1, w);
    idle(0);

    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("sb_drained", 32'(sb.size()), 32'd0);
    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
